vga_sync_decoder: RTL and testbench

Receive-side VGA timing decoder for 640x480 @ 60 Hz on the 25 MHz pixel clock. It takes active-low HSYNC/VSYNC, measures line period, frame length and both pulse widths, and locks after consecutive clean frames. It regenerates pixel coordinates with a flywheel and flags timing violations. It sits at the far end of the VGA timing path: a loop-back checker on the board, and a self-check monitor for the timing generator in simulation.

---
 rtl/vga_sync_decoder.sv | 194 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures HSYNC/VSYNC timing, locks after clean
// frames, and regenerates pixel coordinates with a flywheel that re-aligns on sync edges.
module vga_sync_decoder #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_DISPLAY   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_ALIGN  = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic        locked,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        frame_sync,
  output logic        timing_err,
  output logic [7:0]  err_count,
  output logic [10:0] line_len
);

  localparam logic [10:0] CNT_MAX  = 11'h7FF;
  localparam logic [9:0]  X_RELOAD = 10'(H_DISPLAY + H_FP + SYNC_ALIGN);
  localparam logic [9:0]  Y_RELOAD = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
  localparam int          GOOD_W   = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t            state_q;
  logic [GOOD_W-1:0] good_q;
  logic              err_seen_q;
  logic              locked_q;

  logic        hs_prev_q, vs_prev_q;
  logic [9:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0] h_per_q, h_per_d, h_wid_q, h_wid_d;
  logic [10:0] lines_q, lines_d, v_wid_q, v_wid_d;
  logic [10:0] line_len_q, line_len_d;
  logic        h_valid_q, h_valid_d, v_valid_q, v_valid_d;
  logic        frame_sync_q, timing_err_q;
  logic [7:0]  err_count_q, err_count_d;

  logic h_fall, h_rise, v_fall, v_rise;
  logic x_wrap, loss, check_err, err_pulse;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  always_comb begin
    h_fall = hs_prev_q & ~h_sync_in;
    h_rise = ~hs_prev_q & h_sync_in;
    v_fall = vs_prev_q & ~v_sync_in;
    v_rise = ~vs_prev_q & v_sync_in;
    x_wrap = (x_cnt_q == X_LAST) && !h_fall;

    // Loss fires once, on the transition into saturation, not every saturated cycle.
    loss = !h_fall && (h_per_q == CNT_MAX - 11'd1);

    check_err = (h_fall && h_valid_q && (sat_inc(h_per_q) != 11'(H_TOTAL)))
             || (h_rise && h_valid_q && (h_wid_q != 11'(H_SYNC)))
             || (v_fall && v_valid_q && (lines_q != 11'(V_TOTAL)))
             || (v_rise && v_valid_q && (v_wid_q != 11'(V_SYNC)));
    err_pulse = loss || (check_err && (state_q != SEARCH));

    x_cnt_d = h_fall ? X_RELOAD : (x_cnt_q == X_LAST) ? 10'd0 : x_cnt_q + 10'd1;
    y_cnt_d = y_cnt_q;
    if (v_fall)
      y_cnt_d = Y_RELOAD;
    else if (x_wrap)
      y_cnt_d = (y_cnt_q == Y_LAST) ? 10'd0 : y_cnt_q + 10'd1;

    h_per_d    = h_fall ? 11'd0 : sat_inc(h_per_q);
    line_len_d = h_fall ? sat_inc(h_per_q) : line_len_q;
    h_wid_d    = h_sync_in ? 11'd0 : sat_inc(h_wid_q);
    lines_d    = v_fall ? {10'd0, h_fall} : (h_fall ? sat_inc(lines_q) : lines_q);
    v_wid_d    = v_sync_in ? 11'd0 : (h_fall ? sat_inc(v_wid_q) : v_wid_q);

    h_valid_d = loss ? 1'b0 : (h_fall ? 1'b1 : h_valid_q);
    v_valid_d = loss ? 1'b0 : (v_fall ? 1'b1 : v_valid_q);

    err_count_d = (err_pulse && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      h_per_q      <= '0;
      h_wid_q      <= '0;
      lines_q      <= '0;
      v_wid_q      <= '0;
      line_len_q   <= '0;
      h_valid_q    <= 1'b0;
      v_valid_q    <= 1'b0;
      frame_sync_q <= 1'b0;
      timing_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      hs_prev_q    <= h_sync_in;
      vs_prev_q    <= v_sync_in;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      h_per_q      <= h_per_d;
      h_wid_q      <= h_wid_d;
      lines_q      <= lines_d;
      v_wid_q      <= v_wid_d;
      line_len_q   <= line_len_d;
      h_valid_q    <= h_valid_d;
      v_valid_q    <= v_valid_d;
      frame_sync_q <= v_fall;
      timing_err_q <= err_pulse;
      err_count_q  <= err_count_d;
    end
  end

  // good_q counts clean frames; err_seen_q remembers an error earlier in the current frame.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      err_seen_q <= 1'b0;
      locked_q   <= 1'b0;
    end else if (loss) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      err_seen_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (v_fall) begin
            state_q    <= VERIFY;
            good_q     <= '0;
            err_seen_q <= 1'b0;
          end
        end
        VERIFY: begin
          if (v_fall) begin
            err_seen_q <= 1'b0;
            if (!err_seen_q && !check_err) begin
              if (good_q == GOOD_W'(LOCK_FRAMES - 1)) begin
                state_q  <= LOCKED;
                good_q   <= '0;
                locked_q <= 1'b1;
              end else begin
                good_q <= good_q + GOOD_W'(1);
              end
            end else begin
              good_q <= '0;
            end
          end else if (check_err) begin
            good_q     <= '0;
            err_seen_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (check_err) begin
            state_q    <= VERIFY;
            good_q     <= '0;
            err_seen_q <= !v_fall;
            locked_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          good_q   <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = locked_q;
  assign pixel_x    = x_cnt_q;
  assign pixel_y    = y_cnt_q;
  assign video_on   = locked_q && (x_cnt_q < 10'(H_DISPLAY)) && (y_cnt_q < 10'(V_DISPLAY));
  assign frame_sync = frame_sync_q;
  assign timing_err = timing_err_q;
  assign err_count  = err_count_q;
  assign line_len   = line_len_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced-size registered-sync timing generator drives the
// decoder through acquisition, alignment, line/pulse errors, sync loss and mid-run reset.
module tb_vga_sync_decoder;

  // Scaled-down timing keeps each frame short; every relation of the full mode still holds.
  localparam int HD = 64, HF = 8, HS = 12, HT = 100;
  localparam int VD = 16, VF = 3, VS = 2, VT = 26;
  localparam int FRAME = HT * VT;  // 2600 clocks

  logic pixel_clk = 1'b0;
  logic reset     = 1'b1;
  logic hold_high = 1'b0;
  logic stall_req = 1'b0;
  logic short_req = 1'b0;
  logic hs_gen    = 1'b1;
  logic vs_gen    = 1'b1;
  int   h_cnt     = 0;
  int   v_cnt     = 0;

  logic        h_sync_in, v_sync_in;
  logic        locked, video_on, frame_sync, timing_err;
  logic [9:0]  pixel_x, pixel_y;
  logic [7:0]  err_count;
  logic [10:0] line_len;

  int tests_run    = 0;
  int tests_failed = 0;

  assign h_sync_in = hs_gen | hold_high;
  assign v_sync_in = vs_gen;

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT),
    .SYNC_ALIGN(2), .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .h_sync_in (h_sync_in),
    .v_sync_in (v_sync_in),
    .locked    (locked),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .frame_sync(frame_sync),
    .timing_err(timing_err),
    .err_count (err_count),
    .line_len  (line_len)
  );

  always #20 pixel_clk = ~pixel_clk;

  // Timing generator with registered syncs; stall_req stretches a line, short_req trims HSYNC.
  always @(posedge pixel_clk) begin
    if (h_cnt == HT - 1) begin
      if (!stall_req) begin
        h_cnt <= 0;
        v_cnt <= (v_cnt == VT - 1) ? 0 : v_cnt + 1;
      end
    end else begin
      h_cnt <= h_cnt + 1;
    end
    hs_gen <= !((h_cnt >= HD + HF) && (h_cnt < HD + HF + HS - (short_req ? 1 : 0)));
    vs_gen <= !((v_cnt >= VD + VF) && (v_cnt < VD + VF + VS));
  end

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: simulation exceeded 150000 cycles");
    $fatal(1);
  end

  task automatic tick();
    @(negedge pixel_clk);
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(h_cnt == h && v_cnt == v) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (n >= 2 * FRAME) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_pos: generator at (%0d,%0d), required (%0d,%0d)", h_cnt, v_cnt, h, v);
    end
  endtask

  task automatic wait_fs(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!frame_sync && cycles < 2 * FRAME);
    if (!frame_sync) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_fs: no frame_sync within %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests_run++;
    if ({locked, video_on, frame_sync, timing_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: locked/video_on/frame_sync/timing_err=%b required 0000",
               {locked, video_on, frame_sync, timing_err});
    end
    tests_run++;
    if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_xy: pixel_x=%0d pixel_y=%0d required 0 0", pixel_x, pixel_y);
    end
    tests_run++;
    if (err_count !== 8'd0 || line_len !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: err_count=%0d line_len=%0d required 0 0", err_count, line_len);
    end
    reset = 1'b0;
    $display("[TB] reset released at gen (%0d,%0d)", h_cnt, v_cnt);
  endtask

  task automatic test_acquire();
    int c;
    for (int n = 1; n <= 3; n++) begin
      wait_fs(c);
      $display("[TB] acquire: frame_sync %0d locked=%0b", n, locked);
      tests_run++;
      if (locked !== (n == 3)) begin
        tests_failed++;
        $display("FAIL acquire_locked_%0d: locked=%b required %b", n, locked, (n == 3));
      end
    end
    tests_run++;
    if (err_count !== 8'd0 || line_len !== 11'd100) begin
      tests_failed++;
      $display("FAIL acquire_meas: err_count=%0d line_len=%0d required 0 100", err_count, line_len);
    end
  endtask

  task automatic test_alignment();
    int x_bad = 0, y_bad = 0, v_bad = 0, e_bad = 0, fs_n = 0, last_fs = 0, gap_bad = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      tick();
      if (int'(pixel_x) != h_cnt) x_bad++;
      if (int'(pixel_y) != v_cnt) y_bad++;
      if (video_on !== ((h_cnt < HD) && (v_cnt < VD))) v_bad++;
      if (timing_err !== 1'b0 || locked !== 1'b1) e_bad++;
      if (frame_sync) begin
        fs_n++;
        if (i - last_fs != FRAME) gap_bad++;
        last_fs = i;
      end
    end
    $display("[TB] alignment: 2 frames checked, %0d frame_sync pulses", fs_n);
    tests_run++;
    if (x_bad != 0 || y_bad != 0) begin
      tests_failed++;
      $display("FAIL align_xy: %0d x and %0d y mismatch cycles, required 0", x_bad, y_bad);
    end
    tests_run++;
    if (v_bad != 0) begin
      tests_failed++;
      $display("FAIL align_video_on: %0d mismatch cycles, required 0", v_bad);
    end
    tests_run++;
    if (e_bad != 0) begin
      tests_failed++;
      $display("FAIL align_stable: %0d cycles with timing_err or !locked, required 0", e_bad);
    end
    tests_run++;
    if (fs_n != 2 || gap_bad != 0) begin
      tests_failed++;
      $display("FAIL align_frame_sync: %0d pulses, %0d bad gaps, required 2 pulses every %0d",
               fs_n, gap_bad, FRAME);
    end
  endtask

  task automatic test_long_line();
    int c;
    wait_pos(99, 3);
    stall_req = 1'b1;
    tick();
    stall_req = 1'b0;
    wait_pos(73, 4);
    tests_run++;
    if (timing_err !== 1'b0 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL long_pre: timing_err=%b locked=%b required 0 1", timing_err, locked);
    end
    tick();
    $display("[TB] long line: timing_err=%0b locked=%0b err_count=%0d line_len=%0d",
             timing_err, locked, err_count, line_len);
    tests_run++;
    if (timing_err !== 1'b1 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_err: timing_err=%b locked=%b required 1 0", timing_err, locked);
    end
    tests_run++;
    if (err_count !== 8'd1 || line_len !== 11'd101) begin
      tests_failed++;
      $display("FAIL long_meas: err_count=%0d line_len=%0d required 1 101", err_count, line_len);
    end
    tick();
    tests_run++;
    if (timing_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_single: timing_err=%b on following cycle required 0", timing_err);
    end
    for (int n = 1; n <= 3; n++) begin
      wait_fs(c);
      tests_run++;
      if (locked !== (n == 3)) begin
        tests_failed++;
        $display("FAIL long_relock_%0d: locked=%b required %b", n, locked, (n == 3));
      end
    end
  endtask

  task automatic test_short_pulse();
    int c;
    wait_pos(50, 3);
    short_req = 1'b1;
    wait_pos(84, 3);
    tests_run++;
    if (timing_err !== 1'b0 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL short_pre: timing_err=%b locked=%b required 0 1", timing_err, locked);
    end
    tick();
    short_req = 1'b0;
    $display("[TB] short hsync: timing_err=%0b locked=%0b err_count=%0d",
             timing_err, locked, err_count);
    tests_run++;
    if (timing_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL short_err: timing_err=%b locked=%b err_count=%0d required 1 0 2",
               timing_err, locked, err_count);
    end
    for (int n = 1; n <= 3; n++) begin
      wait_fs(c);
      tests_run++;
      if (locked !== (n == 3)) begin
        tests_failed++;
        $display("FAIL short_relock_%0d: locked=%b required %b", n, locked, (n == 3));
      end
    end
  endtask

  task automatic test_loss();
    int c = 0, n = 0;
    logic got = 1'b0, prev_locked = 1'b0;
    wait_pos(90, 22);
    hold_high = 1'b1;
    // Last h_fall was detected 17 clocks earlier; loss is flagged 2048 clocks after it.
    while (c < 3000 && !got) begin
      prev_locked = locked;
      tick();
      c++;
      got = timing_err;
    end
    $display("[TB] loss: timing_err after %0d cycles, locked=%0b err_count=%0d",
             c, locked, err_count);
    tests_run++;
    if (!got || c != 2031) begin
      tests_failed++;
      $display("FAIL loss_time: timing_err after %0d cycles (seen=%b), required 2031", c, got);
    end
    tests_run++;
    if (prev_locked !== 1'b1 || locked !== 1'b0 || err_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL loss_state: locked %b->%b err_count=%0d required 1->0 3",
               prev_locked, locked, err_count);
    end
    tick();
    tests_run++;
    if (timing_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL loss_single: timing_err=%b on following cycle required 0", timing_err);
    end
    while (h_cnt != 0 && n < HT) begin
      tick();
      n++;
    end
    hold_high = 1'b0;
    wait_pos(74, 18);
    tests_run++;
    if (line_len !== 11'd2047) begin
      tests_failed++;
      $display("FAIL loss_line_len_sat: line_len=%0d required 2047", line_len);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_fs(c);
      tests_run++;
      if (locked !== (k == 3)) begin
        tests_failed++;
        $display("FAIL loss_relock_%0d: locked=%b required %b", k, locked, (k == 3));
      end
    end
    tests_run++;
    if (line_len !== 11'd100 || err_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL loss_after: line_len=%0d err_count=%0d required 100 3", line_len, err_count);
    end
  endtask

  task automatic test_reset_locked();
    int c;
    wait_pos(30, 5);
    tests_run++;
    if (locked !== 1'b1 || err_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL rst_pre: locked=%b err_count=%0d required 1 3", locked, err_count);
    end
    reset = 1'b1;
    tick();
    $display("[TB] reset while locked: locked=%0b x=%0d y=%0d err_count=%0d line_len=%0d",
             locked, pixel_x, pixel_y, err_count, line_len);
    tests_run++;
    if ({locked, video_on, frame_sync, timing_err} !== 4'b0000 ||
        pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
      tests_failed++;
      $display("FAIL rst_outputs: flags=%b x=%0d y=%0d required 0000 0 0",
               {locked, video_on, frame_sync, timing_err}, pixel_x, pixel_y);
    end
    tests_run++;
    if (err_count !== 8'd0 || line_len !== 11'd0) begin
      tests_failed++;
      $display("FAIL rst_counts: err_count=%0d line_len=%0d required 0 0", err_count, line_len);
    end
    wait_pos(40, 5);
    reset = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      wait_fs(c);
      tests_run++;
      if (locked !== (n == 3)) begin
        tests_failed++;
        $display("FAIL rst_relock_%0d: locked=%b required %b", n, locked, (n == 3));
      end
    end
    tests_run++;
    if (err_count !== 8'd0 || line_len !== 11'd100) begin
      tests_failed++;
      $display("FAIL rst_after: err_count=%0d line_len=%0d required 0 100", err_count, line_len);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_alignment();
    test_long_line();
    test_short_pulse();
    test_loss();
    test_reset_locked();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
